// File: rtl/key_debouncer.sv
`timescale 1ns/1ps
// Key debouncer: two-flop synchronizer plus per-key counter filter, yielding clean levels and edge pulses.
// Latency: a raw change captured at edge k shows on Keys_Stable/Keys_Press at edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; free-running. Optional Keys_Release port is built only when KEY_RELEASE_PULSE_EN is defined.
module key_debouncer #(
    parameter int NUM_KEYS        = 9,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                IO_Clock,
    input  logic                IO_Reset,
    input  logic [NUM_KEYS-1:0] Keys_Raw,
    output logic [NUM_KEYS-1:0] Keys_Stable,
    output logic [NUM_KEYS-1:0] Keys_Press
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [NUM_KEYS-1:0] Keys_Release
`endif
);

    // Counter is wide enough to hold DEBOUNCE_CYCLES; it only ever counts up to DEBOUNCE_CYCLES-1.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_press;
    logic [CNT_W-1:0]    r_cnt [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_diff;
    logic [NUM_KEYS-1:0] w_accept;

    // Two-flop synchronizer per key; only the second stage is visible to the filter.
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= Keys_Raw;
            r_sync2 <= r_sync1;
        end
    end

    // A change is accepted when the synchronized level has differed from the stable level for the full window.
    always_comb begin
        w_diff   = r_sync2 ^ r_stable;
        w_accept = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // Per-key window counter: any agreeing cycle (a bounce) restarts the window, acceptance also clears it.
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Stable level flips on acceptance; the press pulse marks an accepted 0->1 and lasts one cycle.
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            r_stable <= '0;
            r_press  <= '0;
        end else begin
            r_stable <= r_stable ^ w_accept;
            r_press  <= w_accept & r_sync2;
        end
    end

    assign Keys_Stable = r_stable;
    assign Keys_Press  = r_press;

`ifdef KEY_RELEASE_PULSE_EN
    logic [NUM_KEYS-1:0] r_release;

    // Release pulse marks an accepted 1->0 and lasts one cycle.
    always_ff @(posedge IO_Clock or negedge IO_Reset) begin
        if (!IO_Reset) begin
            r_release <= '0;
        end else begin
            r_release <= w_accept & ~r_sync2;
        end
    end

    assign Keys_Release = r_release;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
`timescale 1ns/1ps
// Bench for key_debouncer with DEBOUNCE_CYCLES=4, NUM_KEYS=9.
// Stimulus pushes expected output events (edge number, stable, press, release) into a queue;
// a negedge monitor pops one entry each time the outputs show a pulse or a stable-level change.
module tb_key_debouncer;

    localparam int N = 9;
    localparam int D = 4;
    // Raw change driven after edge c is captured at c+1 and reported at c+1+1+D.
    localparam int LAT = D + 2;

    logic         IO_Clock;
    logic         IO_Reset;
    logic [N-1:0] Keys_Raw;
    logic [N-1:0] Keys_Stable;
    logic [N-1:0] Keys_Press;
    logic [N-1:0] rel_obs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           edge_no;
        logic [N-1:0] stb;
        logic [N-1:0] prs;
        logic [N-1:0] rls;
    } exp_t;

    exp_t exp_q[$];
    logic [N-1:0] prev_stb = '0;

`ifdef KEY_RELEASE_PULSE_EN
    logic [N-1:0] Keys_Release;
    key_debouncer #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
        .IO_Clock    (IO_Clock),
        .IO_Reset    (IO_Reset),
        .Keys_Raw    (Keys_Raw),
        .Keys_Stable (Keys_Stable),
        .Keys_Press  (Keys_Press),
        .Keys_Release(Keys_Release)
    );
    assign rel_obs = Keys_Release;
`else
    key_debouncer #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D)) dut (
        .IO_Clock    (IO_Clock),
        .IO_Reset    (IO_Reset),
        .Keys_Raw    (Keys_Raw),
        .Keys_Stable (Keys_Stable),
        .Keys_Press  (Keys_Press)
    );
    assign rel_obs = '0;
`endif

    initial IO_Clock = 1'b0;
    always #5 IO_Clock = ~IO_Clock;

    always @(posedge IO_Clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int e, input logic [N-1:0] s, input logic [N-1:0] p, input logic [N-1:0] r);
        exp_t t;
        t.edge_no = e;
        t.stb     = s;
        t.prs     = p;
`ifdef KEY_RELEASE_PULSE_EN
        t.rls     = r;
`else
        t.rls     = '0;
`endif
        exp_q.push_back(t);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge IO_Clock);
    endtask

    // Monitor: any pulse or stable change is an output event and must match the head of the queue.
    always @(negedge IO_Clock) begin
        if (!IO_Reset) begin
            prev_stb = Keys_Stable;
        end else if ((Keys_Press != '0) || (rel_obs != '0) || (Keys_Stable != prev_stb)) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL unexpected_event: edge %0d stable=%h press=%h release=%h, none expected",
                         cyc, Keys_Stable, Keys_Press, rel_obs);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_edge", 32'(cyc), 32'(e.edge_no));
                check("event_stable", 32'(Keys_Stable), 32'(e.stb));
                check("event_press", 32'(Keys_Press), 32'(e.prs));
                check("event_release", 32'(rel_obs), 32'(e.rls));
            end
            prev_stb = Keys_Stable;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        IO_Reset = 1'b0;
        Keys_Raw = '0;
        step(2);
        check("reset_stable", 32'(Keys_Stable), 32'h0);
        check("reset_press", 32'(Keys_Press), 32'h0);
        check("reset_release", 32'(rel_obs), 32'h0);
        IO_Reset = 1'b1;
        step(2);

        // Clean press on key 3, then release
        Keys_Raw[3] = 1'b1;
        expect_ev(cyc + LAT, 9'h008, 9'h008, 9'h000);
        step(10);
        Keys_Raw[3] = 1'b0;
        expect_ev(cyc + LAT, 9'h000, 9'h000, 9'h008);
        step(10);

        // Bounce on key 0: 1,0,1,0 then hold 1
        Keys_Raw[0] = 1'b1; step(1);
        Keys_Raw[0] = 1'b0; step(1);
        Keys_Raw[0] = 1'b1; step(1);
        Keys_Raw[0] = 1'b0; step(1);
        Keys_Raw[0] = 1'b1;
        expect_ev(cyc + LAT, 9'h001, 9'h001, 9'h000);
        step(12);
        Keys_Raw[0] = 1'b0;
        expect_ev(cyc + LAT, 9'h000, 9'h000, 9'h001);
        step(10);

        // All keys at once
        Keys_Raw = 9'h1FF;
        expect_ev(cyc + LAT, 9'h1FF, 9'h1FF, 9'h000);
        step(10);
        Keys_Raw = 9'h000;
        expect_ev(cyc + LAT, 9'h000, 9'h000, 9'h1FF);
        step(10);

        // Release on key 5: press must stay 0 on the release event
        Keys_Raw[5] = 1'b1;
        expect_ev(cyc + LAT, 9'h020, 9'h020, 9'h000);
        step(10);
        Keys_Raw[5] = 1'b0;
        expect_ev(cyc + LAT, 9'h000, 9'h000, 9'h020);
        step(10);

        // Glitch on key 7 shorter than the window: no event expected
        Keys_Raw[7] = 1'b1;
        step(3);
        Keys_Raw[7] = 1'b0;
        step(10);

        // Key 8 debounced high, then key 2 raised and reset asserted mid-count
        Keys_Raw[8] = 1'b1;
        expect_ev(cyc + LAT, 9'h100, 9'h100, 9'h000);
        step(10);
        Keys_Raw[2] = 1'b1;
        step(2);
        IO_Reset = 1'b0;
        #1;
        check("midreset_stable", 32'(Keys_Stable), 32'h0);
        check("midreset_press", 32'(Keys_Press), 32'h0);
        check("midreset_release", 32'(rel_obs), 32'h0);
        step(3);
        IO_Reset = 1'b1;
        // Both held keys are reported as fresh presses after the full latency
        expect_ev(cyc + LAT, 9'h104, 9'h104, 9'h000);
        step(12);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
